// File: rtl/spi_slave_core_if.sv
// -----------------------------------------------------------------------------
// spi_slave_core_if
// Byte-level bus between the SPI slave engine and the register/command logic.
//
// Handshake rules:
//   rx_valid is a level meaning "rx_data holds an unconsumed byte". The consumer
//   pulses rx_ack for one clk cycle to accept it. A new byte completing while
//   rx_valid is high overwrites rx_data and pulses overrun for one cycle unless
//   rx_ack is high in that same cycle. rx_ack while rx_valid is low is ignored.
//   tx_load (single cycle or level) copies tx_data into the one-deep holding
//   register, which is reused for every transmitted byte until reloaded.
//
// Signals:
//   rx_data      core -> user  last completed received byte
//   rx_valid     core -> user  rx_data unconsumed
//   rx_ack       user -> core  accept rx_data
//   tx_data      user -> core  next byte to transmit
//   tx_load      user -> core  write tx_data into the holding register
//   frame_active core -> user  synchronised chip select asserted
//   overrun      core -> user  one-cycle pulse, unacked byte overwritten
// Modports: slave = SPI core side, master = register/command logic side.
// -----------------------------------------------------------------------------
interface spi_slave_core_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       frame_active;
  logic       overrun;

  modport slave (
    output rx_data, rx_valid, frame_active, overrun,
    input  rx_ack, tx_data, tx_load
  );

  modport master (
    input  rx_data, rx_valid, frame_active, overrun,
    output rx_ack, tx_data, tx_load
  );
endinterface

// File: rtl/spi_slave_core.sv
// -----------------------------------------------------------------------------
// spi_slave_core
// SPI mode-0 (CPOL=0, CPHA=0) slave engine clocked entirely by the system clock.
// The raw SCLK/CS_N/MOSI pins are oversampled through SYNC_STAGES-deep
// synchronisers; edges are found by comparing the last synchroniser stage with
// one extra flop. MOSI is deserialised into bytes, a transmit byte is
// serialised onto MISO.
//
// Build option: define SPI_SLAVE_LSB_FIRST_EN for LSB-first shifting on both
// MOSI and MISO. Default (undefined) is MSB-first.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   sclk_in         raw SPI clock pin
//   cs_n_in         raw chip select pin, active-low
//   mosi_in         raw MOSI pin
//   miso_out        MISO data (0 outside a frame)
//   miso_oe         MISO output enable, high while the frame is selected
//   state_dbg       FSM state (0 = IDLE, 1 = SHIFT)
//   bit_cnt_dbg     bits received in the current byte
//   bus             byte-level rx/tx handshake (spi_slave_core_if.slave)
// -----------------------------------------------------------------------------
module spi_slave_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sclk_in,
  input  logic                   cs_n_in,
  input  logic                   mosi_in,
  output logic                   miso_out,
  output logic                   miso_oe,
  output logic                   state_dbg,
  output logic [2:0]             bit_cnt_dbg,
  spi_slave_core_if.slave        bus
);

  localparam int LAST = SYNC_STAGES - 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Synchronisers and edge-detect flops
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q,   cs_prev_d;

  // Engine state
  logic [0:0] state_q,    state_d;
  logic [2:0] bit_cnt_q,  bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] tx_hold_q,  tx_hold_d;
  logic       miso_bit_q, miso_bit_d;
  logic [7:0] rx_data_q,  rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       overrun_q,  overrun_d;

  // Combinational helpers
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;
  logic       byte_done;
  logic [7:0] rx_shift_in;
  logic [7:0] tx_shifted;
  logic       tx_out_bit;

  always_comb begin
    sclk_sync_d = sclk_sync_q;
    cs_sync_d   = cs_sync_q;
    mosi_sync_d = mosi_sync_q;
    sclk_prev_d = sclk_prev_q;
    cs_prev_d   = cs_prev_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    tx_hold_d   = tx_hold_q;
    miso_bit_d  = 1'b0;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = 1'b0;
    byte_done   = 1'b0;

    // Shift each synchroniser towards its last stage (index LAST)
    if (SYNC_STAGES > 1) begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   cs_n_in};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
    end else begin
      sclk_sync_d[0] = sclk_in;
      cs_sync_d[0]   = cs_n_in;
      mosi_sync_d[0] = mosi_in;
    end
    sclk_prev_d = sclk_sync_q[LAST];
    cs_prev_d   = cs_sync_q[LAST];

    sclk_rise = sclk_sync_q[LAST]  & ~sclk_prev_q;
    sclk_fall = ~sclk_sync_q[LAST] &  sclk_prev_q;
    cs_fall   = ~cs_sync_q[LAST]   &  cs_prev_q;
    cs_rise   = cs_sync_q[LAST]    & ~cs_prev_q;
    mosi_s    = mosi_sync_q[LAST];

`ifdef SPI_SLAVE_LSB_FIRST_EN
    rx_shift_in = {mosi_s, rx_shift_q[7:1]};
    tx_shifted  = {1'b0, tx_shift_q[7:1]};
    tx_out_bit  = tx_shift_q[0];
`else
    rx_shift_in = {rx_shift_q[6:0], mosi_s};
    tx_shifted  = {tx_shift_q[6:0], 1'b0};
    tx_out_bit  = tx_shift_q[7];
`endif

    if (bus.tx_load) begin
      tx_hold_d = bus.tx_data;
    end

    case (state_q)
      ST_IDLE: begin
        // SCLK edges are ignored here; only a select starts a frame.
        if (cs_fall) begin
          state_d    = ST_SHIFT;
          tx_shift_d = tx_hold_q;
          bit_cnt_d  = 3'd0;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          // Deselect drops any partial byte; rx_data/rx_valid untouched.
          state_d   = ST_IDLE;
          bit_cnt_d = 3'd0;
        end else if (sclk_rise) begin
          rx_shift_d = rx_shift_in;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          byte_done  = (bit_cnt_q == 3'd7);
        end else if (sclk_fall) begin
          // bit_cnt==0 on a falling edge means a byte just finished:
          // fetch the next byte instead of shifting out a stale bit.
          if (bit_cnt_q == 3'd0) begin
            tx_shift_d = tx_hold_q;
          end else begin
            tx_shift_d = tx_shifted;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = 3'd0;
      end
    endcase

    // MISO is re-registered so it is glitch-free; the extra cycle is part
    // of the documented SCLK-fall-to-MISO latency.
    miso_bit_d = (state_q == ST_SHIFT) ? tx_out_bit : 1'b0;

    if (byte_done) begin
      rx_data_d  = rx_shift_in;
      rx_valid_d = 1'b1;
      overrun_d  = rx_valid_q & ~bus.rx_ack;
    end else if (bus.rx_ack) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      tx_hold_q   <= 8'h00;
      miso_bit_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      tx_hold_q   <= tx_hold_d;
      miso_bit_q  <= miso_bit_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Gating with the state drops MISO in the same cycle the frame ends.
  assign miso_out         = miso_bit_q & (state_q == ST_SHIFT);
  assign miso_oe          = (state_q == ST_SHIFT);
  assign state_dbg        = state_q[0];
  assign bit_cnt_dbg      = bit_cnt_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.frame_active = (state_q == ST_SHIFT);
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_core
// Drives SPI mode-0 frames on the raw pins and compares every output of
// spi_slave_core each cycle against a pin-event model: the model sees each
// pin SYNC_STAGES+1 cycles late and applies the frame/byte/handshake rules
// with plain integer arithmetic. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_spi_slave_core;

  localparam int SYNC = 2;

  typedef struct packed {
    logic sclk;
    logic cs_n;
    logic mosi;
  } pins_t;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic miso_out, miso_oe, state_dbg;
  logic [2:0] bit_cnt_dbg;

  always #5 clk = ~clk;

  spi_slave_core_if bus ();

  spi_slave_core #(.SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk_in     (sclk),
    .cs_n_in     (cs_n),
    .mosi_in     (mosi),
    .miso_out    (miso_out),
    .miso_oe     (miso_oe),
    .state_dbg   (state_dbg),
    .bit_cnt_dbg (bit_cnt_dbg),
    .bus         (bus)
  );

  // ---------------------------------------------------------------- checking
  int n_chk  = 0;
  int n_pass = 0;
  int ovr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic tx_bit(input logic [7:0] b, input int idx);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return b[idx & 7];
`else
    return b[7 - (idx & 7)];
`endif
  endfunction

  // ---------------------------------------------------------------- model
  pins_t      hist[$];
  pins_t      cur, pd, pp;
  logic       m_active;
  int         m_nbits;
  logic [7:0] m_rx_acc;
  logic [7:0] m_cur_tx;
  int         m_txidx;
  logic [7:0] m_hold;
  logic [7:0] m_rx_data;
  logic       m_rx_valid;
  logic       m_ovr;
  logic       m_pres;
  logic       pres_new, done;
  logic       e_cs_fall, e_cs_rise, e_sclk_rise, e_sclk_fall;

  task automatic model_reset();
    m_active = 1'b0; m_nbits = 0; m_rx_acc = 8'h00; m_cur_tx = 8'h00;
    m_txidx = 0; m_hold = 8'h00; m_rx_data = 8'h00; m_rx_valid = 1'b0;
    m_ovr = 1'b0; m_pres = 1'b0;
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < SYNC + 2; i++) hist.push_back(pins_t'(3'b010));
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      // Synchronisers are held at their reset values while in reset.
      hist.push_back(pins_t'(3'b010));
      model_reset();
    end else begin
      cur = '{sclk: sclk, cs_n: cs_n, mosi: mosi};
      hist.push_back(cur);
      // Pin levels as the core sees them this cycle, and one cycle earlier.
      pd = hist[hist.size() - 1 - SYNC];
      pp = hist[hist.size() - 2 - SYNC];
      e_cs_fall   = pp.cs_n & ~pd.cs_n;
      e_cs_rise   = ~pp.cs_n & pd.cs_n;
      e_sclk_rise = ~pp.sclk & pd.sclk;
      e_sclk_fall = pp.sclk & ~pd.sclk;
      pres_new = m_active ? tx_bit(m_cur_tx, m_txidx) : 1'b0;
      done  = 1'b0;
      m_ovr = 1'b0;
      if (!m_active) begin
        if (e_cs_fall) begin
          m_active = 1'b1; m_cur_tx = m_hold; m_txidx = 0; m_nbits = 0;
        end
      end else if (e_cs_rise) begin
        m_active = 1'b0; m_nbits = 0;
      end else if (e_sclk_rise) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
        m_rx_acc = (m_rx_acc >> 1) | (8'(pd.mosi) << 7);
`else
        m_rx_acc = 8'((int'(m_rx_acc) * 2 + int'(pd.mosi)) % 256);
`endif
        m_nbits++;
        if (m_nbits == 8) begin
          done = 1'b1; m_nbits = 0;
        end
      end else if (e_sclk_fall) begin
        if (m_nbits == 0) begin
          m_cur_tx = m_hold; m_txidx = 0;
        end else begin
          m_txidx++;
        end
      end
      if (done) begin
        m_ovr = m_rx_valid & ~bus.rx_ack;
        m_rx_valid = 1'b1;
        m_rx_data = m_rx_acc;
      end else if (bus.rx_ack) begin
        m_rx_valid = 1'b0;
      end
      if (bus.tx_load) m_hold = bus.tx_data;
      m_pres = pres_new;
    end
    if (hist.size() > 16) void'(hist.pop_front());
    #1;
    chk("miso_out",     32'(miso_out),         32'(m_active & m_pres));
    chk("miso_oe",      32'(miso_oe),          32'(m_active));
    chk("frame_active", 32'(bus.frame_active), 32'(m_active));
    chk("rx_valid",     32'(bus.rx_valid),     32'(m_rx_valid));
    chk("rx_data",      32'(bus.rx_data),      32'(m_rx_data));
    chk("overrun",      32'(bus.overrun),      32'(m_ovr));
    if (bus.overrun === 1'b1) ovr_cnt++;
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] b);
    bus.tx_data = b; bus.tx_load = 1'b1; tick(1);
    bus.tx_load = 1'b0; tick(2);
  endtask

  task automatic ack();
    bus.rx_ack = 1'b1; tick(1); bus.rx_ack = 1'b0; tick(2);
  endtask

  task automatic frame_begin();
    cs_n = 1'b0; tick(8);
  endtask

  task automatic frame_end(input int half);
    tick(half); cs_n = 1'b1; tick(10);
  endtask

  // One byte in mode 0; returns the byte seen on MISO by the master.
  // ack_collide raises rx_ack exactly in the cycle the byte completes.
  // nbits < 8 stops early (aborted byte).
  task automatic spi_byte(input logic [7:0] b, input int half, input bit ack_collide,
                          input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
      mosi = b[i];
`else
      mosi = b[7-i];
`endif
      sclk = 1'b0;
      tick(half);
`ifdef SPI_SLAVE_LSB_FIRST_EN
      got[i] = miso_out;
`else
      got[7-i] = miso_out;
`endif
      sclk = 1'b1;
      if (ack_collide && i == 7) begin
        tick(SYNC); bus.rx_ack = 1'b1; tick(1); bus.rx_ack = 1'b0;
        tick(half - SYNC - 1);
      end else begin
        tick(half);
      end
    end
    sclk = 1'b0;
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------- stimulus
  logic [7:0] got;
  int         ovr0;

  initial begin
    bus.rx_ack = 1'b0; bus.tx_load = 1'b0; bus.tx_data = 8'h00;
    tick(4);
    chk("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("reset_miso_oe",  32'(miso_oe),      32'd0);
    chk("reset_rx_data",  32'(bus.rx_data),  32'd0);
    rst_n = 1'b1;
    tick(3);

    // Basic transfer
    load_tx(8'hA5);
    frame_begin();
    spi_byte(8'h3C, 4, 1'b0, 8, got);
    frame_end(4);
    chk("basic_miso_byte", 32'(got), 32'hA5);
    chk("basic_rx_data",   32'(bus.rx_data), 32'h3C);
    chk("basic_model_rx",  32'(m_rx_data),   32'h3C);
    chk("basic_rx_valid",  32'(bus.rx_valid), 32'd1);
    ack();
    chk("basic_acked", 32'(bus.rx_valid), 32'd0);

    // Multi-byte without acks: one overrun
    ovr0 = ovr_cnt;
    frame_begin();
    spi_byte(8'h11, 5, 1'b0, 8, got);
    spi_byte(8'h22, 5, 1'b0, 8, got);
    frame_end(5);
    chk("multi_rx_data",  32'(bus.rx_data), 32'h22);
    chk("multi_overruns", 32'(ovr_cnt - ovr0), 32'd1);
    ack();

    // Multi-byte with acks: no overrun
    ovr0 = ovr_cnt;
    frame_begin();
    spi_byte(8'h11, 5, 1'b0, 8, got); tick(5); ack();
    spi_byte(8'h22, 5, 1'b0, 8, got); tick(5); ack();
    frame_end(5);
    chk("acked_overruns", 32'(ovr_cnt - ovr0), 32'd0);

    // Ack collides with completion of the 2nd byte
    ovr0 = ovr_cnt;
    frame_begin();
    spi_byte(8'h5C, 6, 1'b0, 8, got);
    spi_byte(8'hC3, 6, 1'b1, 8, got);
    frame_end(6);
    chk("collide_rx_valid", 32'(bus.rx_valid), 32'd1);
    chk("collide_rx_data",  32'(bus.rx_data),  32'hC3);
    chk("collide_overruns", 32'(ovr_cnt - ovr0), 32'd0);
    ack();

    // Aborted byte after 5 rising edges, then a full frame
    frame_begin();
    spi_byte(8'hFF, 5, 1'b0, 5, got);
    frame_end(5);
    chk("abort_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("abort_rx_data",  32'(bus.rx_data),  32'hC3);
    frame_begin();
    spi_byte(8'h81, 5, 1'b0, 8, got);
    frame_end(5);
    chk("after_abort_rx", 32'(bus.rx_data), 32'h81);
    ack();

    // Reset in the middle of a frame
    load_tx(8'h77);
    frame_begin();
    spi_byte(8'hF0, 5, 1'b0, 3, got);
    rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tick(3);
    chk("midrst_miso_oe",  32'(miso_oe),          32'd0);
    chk("midrst_miso_out", 32'(miso_out),         32'd0);
    chk("midrst_frame",    32'(bus.frame_active), 32'd0);
    chk("midrst_rx_data",  32'(bus.rx_data),      32'd0);
    rst_n = 1'b1; tick(4);
    frame_begin();
    spi_byte(8'h5A, 5, 1'b0, 8, got);
    frame_end(5);
    chk("postrst_miso", 32'(got), 32'h00);
    chk("postrst_rx",   32'(bus.rx_data), 32'h5A);
    ack();

`ifdef SPI_SLAVE_LSB_FIRST_EN
    load_tx(8'h01);
    frame_begin();
    chk("lsb_first_bit", 32'(miso_out), 32'd1);
    spi_byte(8'h01, 5, 1'b0, 8, got);
    frame_end(5);
    chk("lsb_rx_data", 32'(bus.rx_data), 32'h01);
    ack();
`endif

    // Randomised frames; the per-cycle model checks every output.
    for (int f = 0; f < 40; f++) begin
      int nb;
      int half;
      nb = $urandom_range(1, 3);
      half = $urandom_range(4, 7);
      if ($urandom_range(0, 1) == 1) load_tx(8'($urandom));
      frame_begin();
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.tx_data = 8'($urandom); bus.tx_load = 1'b1; tick(1); bus.tx_load = 1'b0;
        end
        spi_byte(8'($urandom), half, 1'b0, ($urandom_range(0, 9) == 0) ? 4 : 8, got);
        if ($urandom_range(0, 1) == 1) begin
          tick(SYNC + 2); ack();
        end
      end
      frame_end(half);
    end

    tick(5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

SPI mode-0 slave engine sitting directly upstream of the chip-level TinyTapeout wrapper's output logic: it oversamples the external SCLK/CS_N/MOSI pins in the system clock domain, deserialises MOSI into bytes and serialises a transmit byte onto MISO. Received bytes leave through a valid/ack handshake to the register/command logic. Transmit bytes arrive through a one-deep holding register.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth on `sclk_in`, `cs_n_in` and `mosi_in` (legal values 2..3).
- `clk`  input  1  system clock; the only clock in the block.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `sclk_in`  input  1  raw SPI clock pin (CPOL=0).
- `cs_n_in`  input  1  raw chip select pin, active-low.
- `mosi_in`  input  1  raw MOSI pin.
- `miso_out`  output  1  MISO data.
- `miso_oe`  output  1  MISO output enable; 1 while the frame is selected.
- `rx_data`  output  8  last completed received byte.
- `rx_valid`  output  1  `rx_data` holds an unconsumed byte.
- `rx_ack`  input  1  consumer accepts `rx_data`. Single-cycle pulse.
- `tx_data`  input  8  next byte to transmit.
- `tx_load`  input  1  writes `tx_data` into the holding register.
- `frame_active`  output  1  synchronised CS asserted.
- `overrun`  output  1  one-cycle pulse when an unacked byte is overwritten.

## Operation
- Synchronisers have the following reset values: sclk 0, cs_n 1, mosi 0. Edge detectors compare the last synchroniser stage with one extra flop.
- FSM states:
  - IDLE: synchronised cs_n is high. bit_cnt=0 and the MISO shifter is idle.
  - SHIFT: synchronised cs_n is low.
- IDLE→SHIFT on a detected cs_n falling edge. In that same cycle `tx_shift` <= `tx_hold` and bit_cnt <= 0.
- SHIFT→IDLE on a detected cs_n rising edge from any bit_cnt. A partial byte is discarded: no `rx_valid`, no change to `rx_data`, bit_cnt <= 0.
- SCLK rising edge in SHIFT:
  - `rx_shift` takes the synchronised MOSI.
  - bit_cnt increments modulo 8.
  - On the wrap 7→0: `rx_data` <= completed byte and `rx_valid` <= 1.
- SCLK falling edge in SHIFT:
  - If bit_cnt==0 (a byte has just completed), `tx_shift` <= `tx_hold`.
  - Otherwise `tx_shift` shifts by one.
- SCLK edges in IDLE are ignored.
- `miso_out` = outgoing bit of `tx_shift` while in SHIFT, else 0. `miso_oe` = `frame_active` = (state==SHIFT).
- `tx_hold` is written on any cycle with `tx_load`=1, in either state. It is not cleared on use, so the same byte repeats until it is reloaded.
- RX handshake:
  - `rx_valid` clears on `rx_ack` when no byte completes in that cycle.
  - If a byte completes while `rx_valid`=1 and `rx_ack`=0: data is overwritten, `rx_valid` stays 1, and `overrun` pulses.
  - If a byte completes in the same cycle as `rx_ack`: the new data is loaded, `rx_valid` stays 1, and there is no overrun.
  - `rx_ack` while `rx_valid`=0 is ignored.
- Reset, including mid-frame, returns the block to IDLE with all outputs 0, apart from the synchroniser reset values listed above. `tx_hold` also resets to 0x00, and bit_cnt to 0.

## Timing
- Input-to-detection latency is SYNC_STAGES+1 clk cycles from a pin edge to the internal edge pulse.
- `rx_valid` rises SYNC_STAGES+1 cycles after the 8th SCLK rising edge at the pin.
- `miso_out` updates SYNC_STAGES+2 cycles after the SCLK falling edge at the pin.
- The first bit is valid SYNC_STAGES+2 cycles after CS_N falls.
- Constraints on the external master:
  - f_sclk ≤ f_clk/8.
  - SCLK high and low phases ≥ 4 clk cycles each.
  - CS_N setup before the first SCLK rise ≥ 4 clk cycles.
- `tx_load` must occur at least 2 clk cycles before the falling edge that consumes `tx_hold`.
- `overrun` is exactly one cycle wide. `rx_valid` is level and persists until acked.

## Configuration
- `SPI_SLAVE_LSB_FIRST_EN`:
  - Defined: both shifters are LSB-first. `miso_out`=`tx_shift[0]`, shifting right; MOSI enters at bit 7.
  - Undefined (default): MSB-first. `miso_out`=`tx_shift[7]`, shifting left; MOSI enters at bit 0.
- Handshake, timing and FSM are identical in both builds.

## Test plan
- Basic transfer: reset; `tx_load` 0xA5; master sends 0x3C in mode 0 at clk/8 → MISO bits 1,0,1,0,0,1,0,1; `rx_data`=0x3C; `rx_valid`=1 until `rx_ack`.
- Multi-byte frame: master sends 0x11,0x22 without acking → `rx_data`=0x22, `rx_valid`=1, one `overrun` pulse. Repeat, acking each byte → no overrun.
- Ack collision: `rx_ack` asserted in the exact cycle the 2nd byte completes → `rx_valid` stays 1, `rx_data`=2nd byte, `overrun`=0.
- Aborted byte: CS_N rises after 5 SCLK edges → `rx_valid` is unchanged, and the next full frame 0x81 is received correctly with bit_cnt restarted.
- Reset mid-frame: assert `rst_n`=0 after 3 bits → all outputs 0 and `miso_oe`=0. After release, the next frame transmits 0x00 and receives correctly.
- LSB-first build (`SPI_SLAVE_LSB_FIRST_EN`): `tx_load` 0x01 → MISO emits 1 first; master sends bits 1,0,0,0,0,0,0,0 → `rx_data`=0x01.
